// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM state encodings and default parameters for the pipeline sequencer
package pipe_ctrl_pkg;
   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] DRAIN  = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;
   localparam logic [1:0] ERR    = 2'd3;
   localparam int CNT_W_DEF    = 16;
   localparam int WDOG_CYC_DEF = 64;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones; clk/clr (sync) / inc in, q out
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (clr) q <= '0;
      else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: prioritised stage enables, NOP injection and PC redirect for the 5-stage core
// Inputs: hazStall, brTaken, imemStall, dmemStall, haltID, haltWB; sync active-high rst.
// Outputs: per-stage write enables, flush/bubble, pcRedirect, halted/err/state, stallCnt/flushCnt.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int WDOG_CYC = WDOG_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazStall,
   input  logic             brTaken,
   input  logic             imemStall,
   input  logic             dmemStall,
   input  logic             haltID,
   input  logic             haltWB,
   output logic             PCwriteEn,
   output logic             pcRedirect,
   output logic             IFIDwriteEn,
   output logic             IFIDflush,
   output logic             IDEXwriteEn,
   output logic             IDEXbubble,
   output logic             EXMEMwriteEn,
   output logic             MEMWBwriteEn,
   output logic             halted,
   output logic             err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);
   localparam int WW = WDOG_CYC > 1 ? $clog2(WDOG_CYC) : 1;
   localparam logic [WW-1:0] WD_MAX = WW'(WDOG_CYC - 1);
   logic [WW-1:0] wdog;
   logic [1:0] cs, nxt;
   logic h, b, i, d, inRun, inDrain, live, active, brWin, hzWin, imWin;
   // while rst is high the decode behaves as RUN with every input at 0
   assign cs = rst ? RUN : state;
   assign h = hazStall & ~rst;
   assign b = brTaken & ~rst;
   assign i = imemStall & ~rst;
   assign d = dmemStall & ~rst;
   assign inRun = cs == RUN;
   assign inDrain = cs == DRAIN;
   assign active = (inRun | inDrain) & ~d;
   assign brWin = inRun & ~d & b;
   assign hzWin = inRun & ~d & ~b & h;
   assign imWin = inRun & ~d & ~b & ~h & i;
   assign PCwriteEn = inRun & ~d & (b | (~h & ~i));
   assign pcRedirect = brWin;
   assign IFIDwriteEn = active & ~hzWin;
   assign IFIDflush = brWin | imWin | (inDrain & ~d);
   assign IDEXwriteEn = active;
   assign IDEXbubble = brWin | hzWin | (inDrain & ~d);
   assign EXMEMwriteEn = active;
   assign MEMWBwriteEn = active;
   assign halted = state == HALTED;
   assign err = state == ERR;
   assign live = state == RUN || state == DRAIN;
   always_comb begin
      nxt = state;
      if (live && dmemStall && wdog == WD_MAX) nxt = ERR;
      else if (state == RUN) nxt = (haltID & ~dmemStall & ~brTaken & ~hazStall) ? DRAIN : RUN;
      else if (state == DRAIN) nxt = (haltWB & ~dmemStall) ? HALTED : DRAIN;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= RUN;
         wdog  <= '0;
      end else begin
         state <= nxt;
         wdog  <= !dmemStall ? '0 : live ? wdog + 1'b1 : wdog;
      end
   sat_counter #(.W(CNT_W)) uStall (
      .clk(clk), .clr(rst), .inc(live & ~PCwriteEn), .q(stallCnt)
   );
   sat_counter #(.W(CNT_W)) uFlush (
      .clk(clk), .clr(rst), .inc(brWin), .q(flushCnt)
   );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed-vector bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
   logic clk = 0, rst = 1;
   logic hazStall = 0, brTaken = 0, imemStall = 0, dmemStall = 0, haltID = 0, haltWB = 0;
   logic PCwriteEn, pcRedirect, IFIDwriteEn, IFIDflush, IDEXwriteEn, IDEXbubble;
   logic EXMEMwriteEn, MEMWBwriteEn, halted, err;
   logic [1:0] state;
   logic [3:0] stallCnt, flushCnt;
   logic [7:0] ctl;
   int nVec = 0, nFail = 0;

   // {PC, redirect, IFIDen, IFIDflush, IDEXen, IDEXbubble, EXMEMen, MEMWBen}
   localparam logic [7:0] C_RUN = 8'b1010_1011;
   localparam logic [7:0] C_HAZ = 8'b0000_1111;
   localparam logic [7:0] C_BR  = 8'b1111_1111;
   localparam logic [7:0] C_IM  = 8'b0011_1011;
   localparam logic [7:0] C_DR  = 8'b0011_1111;
   localparam logic [7:0] C_OFF = 8'b0000_0000;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.CNT_W(4), .WDOG_CYC(64)) dut (
      .clk(clk), .rst(rst), .hazStall(hazStall), .brTaken(brTaken), .imemStall(imemStall),
      .dmemStall(dmemStall), .haltID(haltID), .haltWB(haltWB), .PCwriteEn(PCwriteEn),
      .pcRedirect(pcRedirect), .IFIDwriteEn(IFIDwriteEn), .IFIDflush(IFIDflush),
      .IDEXwriteEn(IDEXwriteEn), .IDEXbubble(IDEXbubble), .EXMEMwriteEn(EXMEMwriteEn),
      .MEMWBwriteEn(MEMWBwriteEn), .halted(halted), .err(err), .state(state),
      .stallCnt(stallCnt), .flushCnt(flushCnt)
   );

   assign ctl = {PCwriteEn, pcRedirect, IFIDwriteEn, IFIDflush, IDEXwriteEn, IDEXbubble,
                 EXMEMwriteEn, MEMWBwriteEn};

   task automatic setIn(input logic hz, br, im, dm, hid, hwb);
      hazStall = hz; brTaken = br; imemStall = im; dmemStall = dm; haltID = hid; haltWB = hwb;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1;
      setIn(1, 1, 1, 1, 1, 1);
      nVec++; if (ctl !== C_RUN) begin nFail++; $display("FAIL rst_ctl got %b exp %b", ctl, C_RUN); end
      tick(); tick();
      rst = 0;
      setIn(0, 0, 0, 0, 0, 0);
      nVec++; if (state !== 2'd0) begin nFail++; $display("FAIL rst_state got %0d exp 0", state); end
      nVec++; if ({halted, err} !== 2'b00) begin nFail++; $display("FAIL rst_flags got %b exp 00", {halted, err}); end
      nVec++; if ({stallCnt, flushCnt} !== 8'h00) begin nFail++; $display("FAIL rst_cnt got %h exp 00", {stallCnt, flushCnt}); end
      nVec++; if (ctl !== C_RUN) begin nFail++; $display("FAIL run_ctl got %b exp %b", ctl, C_RUN); end
   endtask

   task automatic test_hazard();
      setIn(1, 0, 0, 0, 0, 0);
      nVec++; if (ctl !== C_HAZ) begin nFail++; $display("FAIL haz_ctl1 got %b exp %b", ctl, C_HAZ); end
      tick();
      nVec++; if (ctl !== C_HAZ) begin nFail++; $display("FAIL haz_ctl2 got %b exp %b", ctl, C_HAZ); end
      nVec++; if (stallCnt !== 4'd1) begin nFail++; $display("FAIL haz_cnt1 got %0d exp 1", stallCnt); end
      tick();
      setIn(0, 0, 0, 0, 0, 0);
      nVec++; if (stallCnt !== 4'd2) begin nFail++; $display("FAIL haz_cnt2 got %0d exp 2", stallCnt); end
   endtask

   task automatic test_branch();
      setIn(1, 1, 1, 0, 0, 0);
      nVec++; if (ctl !== C_BR) begin nFail++; $display("FAIL br_ctl got %b exp %b", ctl, C_BR); end
      tick();
      setIn(0, 0, 0, 0, 0, 0);
      nVec++; if (flushCnt !== 4'd1) begin nFail++; $display("FAIL br_flush got %0d exp 1", flushCnt); end
      nVec++; if (stallCnt !== 4'd2) begin nFail++; $display("FAIL br_stall got %0d exp 2", stallCnt); end
   endtask

   task automatic test_dmem_branch();
      setIn(0, 1, 0, 1, 0, 0);
      nVec++; if (ctl !== C_OFF) begin nFail++; $display("FAIL dmbr_ctl got %b exp %b", ctl, C_OFF); end
      tick();
      setIn(0, 1, 0, 0, 0, 0);
      nVec++; if (ctl !== C_BR) begin nFail++; $display("FAIL dmbr_redir got %b exp %b", ctl, C_BR); end
      tick();
      setIn(0, 0, 0, 0, 0, 0);
      nVec++; if ({stallCnt, flushCnt} !== {4'd3, 4'd2}) begin nFail++; $display("FAIL dmbr_cnt got %h exp 32", {stallCnt, flushCnt}); end
   endtask

   task automatic test_halt();
      setIn(0, 0, 0, 0, 1, 0);
      nVec++; if (ctl !== C_RUN) begin nFail++; $display("FAIL halt_id_ctl got %b exp %b", ctl, C_RUN); end
      tick();
      setIn(1, 1, 1, 0, 1, 0);
      nVec++; if (state !== 2'd1) begin nFail++; $display("FAIL drain_state got %0d exp 1", state); end
      nVec++; if (ctl !== C_DR) begin nFail++; $display("FAIL drain_ctl got %b exp %b", ctl, C_DR); end
      tick(); tick();
      setIn(0, 0, 0, 1, 0, 1);
      nVec++; if (ctl !== C_OFF) begin nFail++; $display("FAIL drain_dm_ctl got %b exp %b", ctl, C_OFF); end
      tick();
      nVec++; if (state !== 2'd1) begin nFail++; $display("FAIL drain_hold got %0d exp 1", state); end
      setIn(0, 0, 0, 0, 0, 1);
      tick();
      setIn(0, 0, 0, 0, 0, 0);
      nVec++; if ({state, halted, err} !== 4'b1010) begin nFail++; $display("FAIL halted got %b exp 1010", {state, halted, err}); end
      nVec++; if (stallCnt !== 4'd7) begin nFail++; $display("FAIL halt_stall got %0d exp 7", stallCnt); end
      nVec++; if (ctl !== C_OFF) begin nFail++; $display("FAIL halted_ctl got %b exp %b", ctl, C_OFF); end
      setIn(1, 1, 1, 1, 1, 1);
      tick(); tick();
      nVec++; if ({state, stallCnt, flushCnt} !== {2'd2, 4'd7, 4'd2}) begin nFail++; $display("FAIL halted_frozen got %h exp 272", {state, stallCnt, flushCnt}); end
      nVec++; if (ctl !== C_OFF) begin nFail++; $display("FAIL halted_ctl2 got %b exp %b", ctl, C_OFF); end
      rst = 1;
      tick();
      rst = 0;
      setIn(0, 0, 0, 0, 0, 0);
      nVec++; if ({state, stallCnt, flushCnt} !== 10'd0) begin nFail++; $display("FAIL halt_rst got %h exp 0", {state, stallCnt, flushCnt}); end
      nVec++; if (ctl !== C_RUN) begin nFail++; $display("FAIL halt_rst_ctl got %b exp %b", ctl, C_RUN); end
   endtask

   task automatic test_watchdog();
      setIn(0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 63; k++) tick();
      nVec++; if ({state, err} !== 3'b000) begin nFail++; $display("FAIL wd63 got %b exp 000", {state, err}); end
      setIn(0, 0, 0, 0, 0, 0);
      tick();
      nVec++; if ({state, err} !== 3'b000) begin nFail++; $display("FAIL wd_rel got %b exp 000", {state, err}); end
      setIn(0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 63; k++) tick();
      nVec++; if (err !== 1'b0) begin nFail++; $display("FAIL wd_clr got %b exp 0", err); end
      tick();
      setIn(0, 1, 0, 0, 0, 0);
      nVec++; if ({state, err} !== 3'b111) begin nFail++; $display("FAIL wd_err got %b exp 111", {state, err}); end
      nVec++; if (ctl !== C_OFF) begin nFail++; $display("FAIL err_ctl got %b exp %b", ctl, C_OFF); end
      nVec++; if (stallCnt !== 4'd15) begin nFail++; $display("FAIL wd_sat got %0d exp 15", stallCnt); end
      tick();
      nVec++; if ({state, flushCnt} !== {2'd3, 4'd0}) begin nFail++; $display("FAIL err_hold got %h exp 30", {state, flushCnt}); end
      rst = 1;
      tick();
      rst = 0;
      setIn(0, 0, 0, 0, 0, 0);
      nVec++; if ({state, err, stallCnt} !== 7'd0) begin nFail++; $display("FAIL err_rst got %h exp 0", {state, err, stallCnt}); end
   endtask

   task automatic test_saturate();
      setIn(0, 0, 1, 0, 0, 0);
      nVec++; if (ctl !== C_IM) begin nFail++; $display("FAIL im_ctl got %b exp %b", ctl, C_IM); end
      for (int k = 0; k < 14; k++) tick();
      nVec++; if (stallCnt !== 4'd14) begin nFail++; $display("FAIL sat14 got %0d exp 14", stallCnt); end
      for (int k = 0; k < 6; k++) tick();
      nVec++; if (stallCnt !== 4'd15) begin nFail++; $display("FAIL sat20 got %0d exp 15", stallCnt); end
      setIn(0, 0, 0, 0, 1, 0);
      tick();
      nVec++; if (state !== 2'd1) begin nFail++; $display("FAIL sat_drain got %0d exp 1", state); end
      rst = 1;
      tick();
      rst = 0;
      setIn(0, 0, 0, 0, 0, 0);
      nVec++; if ({state, stallCnt} !== 6'd0) begin nFail++; $display("FAIL drain_rst got %h exp 0", {state, stallCnt}); end
   endtask

   initial begin
      test_reset();
      test_hazard();
      test_branch();
      test_dmem_branch();
      test_halt();
      test_watchdog();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end
endmodule
